// File: rtl/vram_wr_queue.sv
// rtl/vram_wr_queue.sv - 4-entry CPU write queue drained into VRAM on sequencer phases 4 and 5
module vram_wr_queue (
    input  logic        pixClk,
    input  logic        nReset,
    input  logic [2:0]  seq,
    input  logic        wrReq,
    input  logic [14:0] wrAddr,
    input  logic [7:0]  wrData,
    input  logic        wrBuf,
    output logic [14:0] vramAddr,
    output logic [7:0]  vramDataOut,
    output logic        nvramWE,
    output logic        nvramCE0,
    output logic        nvramCE1,
    output logic [2:0]  count,
    output logic        full,
    output logic        overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR1  = 2'd1;
    localparam logic [1:0] WR2  = 2'd2;

    // Entry layout: {addr[14:0], data[7:0], buf}
    logic [23:0] mem_q [4];
    logic [23:0] head_entry;

    logic [1:0]  state_q, state_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic        full_q, full_d;
    logic        ovf_q, ovf_d;
    logic        first_q;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_n_q, we_n_d;
    logic        ce0_n_q, ce0_n_d;
    logic        ce1_n_q, ce1_n_d;
    logic        push, pop, start;

    assign head_entry = mem_q[head_q];

    always_comb begin
        // first_q masks the request on the first edge out of reset
        push    = wrReq && !first_q && !full_q;
        start   = (state_q == IDLE) && (seq == 3'd3) && (count_q != 3'd0);
        pop     = (state_q == WR2);

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WR1;
            WR1:     state_d = WR2;
            WR2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ovf_d   = ovf_q | (wrReq && !first_q && full_q);
        head_d  = head_q + {1'b0, pop};
        tail_d  = tail_q + {1'b0, push};

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 3'd1;
        else if (pop && !push)
            count_d = count_q - 3'd1;
        full_d  = (count_d == 3'd4);

        addr_d  = addr_q;
        data_d  = data_q;
        we_n_d  = we_n_q;
        ce0_n_d = ce0_n_q;
        ce1_n_d = ce1_n_q;
        if (start) begin
            addr_d  = head_entry[23:9];
            data_d  = head_entry[8:1];
            we_n_d  = 1'b0;
            ce0_n_d = head_entry[0];
            ce1_n_d = !head_entry[0];
        end else if (pop) begin
            we_n_d  = 1'b1;
            ce0_n_d = 1'b1;
            ce1_n_d = 1'b1;
        end
    end

    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
            addr_q  <= 15'd0;
            data_q  <= 8'd0;
            we_n_q  <= 1'b1;
            ce0_n_q <= 1'b1;
            ce1_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            first_q <= 1'b0;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_n_q  <= we_n_d;
            ce0_n_q <= ce0_n_d;
            ce1_n_q <= ce1_n_d;
        end
    end

    // Storage needs no reset; pointers and count define which slots are live
    always_ff @(posedge pixClk) begin
        if (push)
            mem_q[tail_q] <= {wrAddr, wrData, wrBuf};
    end

    assign vramAddr    = addr_q;
    assign vramDataOut = data_q;
    assign nvramWE     = we_n_q;
    assign nvramCE0    = ce0_n_q;
    assign nvramCE1    = ce1_n_q;
    assign count       = count_q;
    assign full        = full_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_vram_wr_queue.sv
// tb/tb_vram_wr_queue.sv - directed and randomized bench for vram_wr_queue against a queue-based model
module tb_vram_wr_queue;

    logic        pixClk = 1'b0;
    logic        nReset = 1'b1;
    logic [2:0]  seq = 3'd0;
    logic        wrReq = 1'b0;
    logic [14:0] wrAddr = 15'd0;
    logic [7:0]  wrData = 8'd0;
    logic        wrBuf = 1'b0;
    logic [14:0] vramAddr;
    logic [7:0]  vramDataOut;
    logic        nvramWE, nvramCE0, nvramCE1;
    logic [2:0]  count;
    logic        full, overflow;

    vram_wr_queue dut (
        .pixClk(pixClk), .nReset(nReset), .seq(seq), .wrReq(wrReq),
        .wrAddr(wrAddr), .wrData(wrData), .wrBuf(wrBuf),
        .vramAddr(vramAddr), .vramDataOut(vramDataOut), .nvramWE(nvramWE),
        .nvramCE0(nvramCE0), .nvramCE1(nvramCE1), .count(count),
        .full(full), .overflow(overflow)
    );

    always #5 pixClk = ~pixClk;

    int checks = 0;
    int failures = 0;

    // Model: a plain queue of pending writes plus the write currently on the bus
    logic [23:0] mq[$];
    logic [23:0] exp_log[$];
    logic [23:0] dut_log[$];
    logic        m_drain = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_first = 1'b1;
    logic [23:0] m_out = 24'd0;
    logic [2:0]  seq_v = 3'd0;
    logic        rst_drive = 1'b0;
    logic        prev_we = 1'b1;
    int          max_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drain = 1'b0;
        m_ovf   = 1'b0;
        m_out   = 24'd0;
        m_first = 1'b1;
    endtask

    task automatic model_edge(input logic rst_lvl, input logic [2:0] s, input logic req, input logic [23:0] e);
        bit pre_full, pre_empty, r;
        if (!rst_lvl) begin
            model_reset();
            return;
        end
        r = req;
        if (m_first) begin
            m_first = 1'b0;
            r = 1'b0;
        end
        pre_full  = (mq.size() == 4);
        pre_empty = (mq.size() == 0);
        if (m_drain && s == 3'd5) begin
            void'(mq.pop_front());
            m_drain = 1'b0;
        end else if (!m_drain && s == 3'd3 && !pre_empty) begin
            m_out   = mq[0];
            m_drain = 1'b1;
            exp_log.push_back(mq[0]);
        end
        if (r) begin
            if (pre_full) m_ovf = 1'b1;
            else          mq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        chk("we",    nvramWE,     !m_drain);
        chk("ce0",   nvramCE0,    !(m_drain && !m_out[0]));
        chk("ce1",   nvramCE1,    !(m_drain && m_out[0]));
        chk("addr",  vramAddr,    m_out[23:9]);
        chk("data",  vramDataOut, m_out[8:1]);
        chk("count", count,       mq.size());
        chk("full",  full,        mq.size() == 4);
        chk("ovf",   overflow,    m_ovf);
    endtask

    task automatic step(input logic req, input logic [14:0] a, input logic [7:0] d, input logic b);
        @(negedge pixClk);
        nReset = rst_drive;
        seq    = seq_v;
        wrReq  = req;
        wrAddr = a;
        wrData = d;
        wrBuf  = b;
        @(posedge pixClk);
        model_edge(rst_drive, seq_v, req, {a, d, b});
        seq_v = seq_v + 3'd1;
        #1;
        check_outputs();
        if (nvramWE === 1'b0)
            chk("we_phase", (seq_v == 3'd4) || (seq_v == 3'd5), 1);
        if (nvramWE === 1'b0 && prev_we === 1'b1)
            dut_log.push_back({vramAddr, vramDataOut, ~nvramCE1});
        prev_we = nvramWE;
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 15'd0, 8'd0, 1'b0);
    endtask

    task automatic wait_seq(input logic [2:0] t);
        while (seq_v != t) step(1'b0, 15'd0, 8'd0, 1'b0);
    endtask

    task automatic clear_logs();
        exp_log.delete();
        dut_log.delete();
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_n"}, dut_log.size(), exp_log.size());
        for (int k = 0; k < dut_log.size() && k < exp_log.size(); k++)
            chk({tag, "_entry"}, dut_log[k], exp_log[k]);
    endtask

    initial begin
        logic [14:0] ra;
        logic [7:0]  rd;

        // Power-up reset, checked before any clock edge
        #1 nReset = 1'b0;
        #1;
        chk("rst_we", nvramWE, 1);
        chk("rst_ce0", nvramCE0, 1);
        chk("rst_ce1", nvramCE1, 1);
        chk("rst_addr", vramAddr, 0);
        chk("rst_data", vramDataOut, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        rst_drive = 1'b0;
        idle(2);
        rst_drive = 1'b1;
        step(1'b1, 15'h0555, 8'h55, 1'b0);
        chk("first_edge_ignored", count, 0);

        // Single write to main buffer
        clear_logs();
        wait_seq(3'd1);
        step(1'b1, 15'h1234, 8'hA5, 1'b0);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        chk("single_we4", nvramWE, 0);
        chk("single_ce0", nvramCE0, 0);
        chk("single_ce1", nvramCE1, 1);
        chk("single_addr", vramAddr, 15'h1234);
        chk("single_data", vramDataOut, 8'hA5);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        chk("single_we5", nvramWE, 0);
        chk("single_addr5", vramAddr, 15'h1234);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        chk("single_count", count, 0);
        chk("single_we_off", nvramWE, 1);
        chk("single_addr_hold", vramAddr, 15'h1234);

        // Alt buffer
        wait_seq(3'd1);
        step(1'b1, 15'h7FFF, 8'hFF, 1'b1);
        idle(2);
        chk("alt_ce1", nvramCE1, 0);
        chk("alt_ce0", nvramCE0, 1);
        chk("alt_addr", vramAddr, 15'h7FFF);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        chk("alt_ce1_wr2", nvramCE1, 0);
        idle(2);

        // Minimum latency: push on the edge just before the seq 3 edge
        wait_seq(3'd2);
        step(1'b1, 15'h0042, 8'h11, 1'b0);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        chk("lat_we", nvramWE, 0);
        chk("lat_addr", vramAddr, 15'h0042);
        idle(8);

        // Fill and overflow
        clear_logs();
        wait_seq(3'd4);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 15'(i), 8'(i + 16), 1'b0);
            if (i == 3) begin
                chk("fill_full", full, 1);
                chk("fill_count", count, 4);
                chk("fill_ovf_pre", overflow, 0);
            end
        end
        chk("fill_ovf", overflow, 1);
        chk("fill_count5", count, 4);
        idle(40);
        chk("fill_drains", dut_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_log.size(); i++)
            chk("fill_order", dut_log[i][23:9], i);
        compare_logs("fill");

        // Simultaneous push and pop
        clear_logs();
        wait_seq(3'd0);
        step(1'b1, 15'h0100, 8'h01, 1'b0);
        step(1'b1, 15'h0101, 8'h02, 1'b0);
        idle(3);
        chk("pp_pre", count, 2);
        step(1'b1, 15'h0102, 8'h03, 1'b1);
        chk("pp_count", count, 2);
        idle(24);
        chk("pp_drains", dut_log.size(), 3);
        if (dut_log.size() == 3)
            chk("pp_last", dut_log[2][23:9], 15'h0102);
        compare_logs("pp");

        // Reset during WR1 with three entries queued
        chk("ovf_sticky", overflow, 1);
        wait_seq(3'd0);
        step(1'b1, 15'h0300, 8'h30, 1'b0);
        step(1'b1, 15'h0301, 8'h31, 1'b1);
        step(1'b1, 15'h0302, 8'h32, 1'b0);
        step(1'b0, 15'd0, 8'd0, 1'b0);
        chk("mid_count", count, 3);
        chk("mid_we", nvramWE, 0);
        #1 nReset = 1'b0;
        rst_drive = 1'b0;
        #1;
        chk("mid_rst_we", nvramWE, 1);
        chk("mid_rst_ce0", nvramCE0, 1);
        chk("mid_rst_ce1", nvramCE1, 1);
        model_reset();
        idle(2);
        rst_drive = 1'b1;
        step(1'b1, 15'h0777, 8'h77, 1'b0);
        chk("mid_after_count", count, 0);
        chk("mid_after_ovf", overflow, 0);
        prev_we = 1'b1;

        // Pointer wrap: ten writes, one per sequence
        clear_logs();
        max_count = 0;
        for (int i = 0; i < 10; i++) begin
            wait_seq(3'd0);
            step(1'b1, 15'(16'h0200 + i), 8'(i), i[0]);
        end
        idle(16);
        chk("wrap_drains", dut_log.size(), 10);
        for (int i = 0; i < 10 && i < dut_log.size(); i++)
            chk("wrap_order", dut_log[i][23:9], 16'h0200 + i);
        chk("wrap_ovf", overflow, 0);
        chk("wrap_peak", max_count, 1);
        compare_logs("wrap");

        // Randomized traffic
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            ra = 15'($urandom);
            rd = 8'($urandom);
            step($urandom_range(0, 3) == 0, ra, rd, 1'($urandom));
        end
        idle(48);
        compare_logs("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
